guess_game_controller: RTL and testbench

- Game-sequencing FSM for the number-guessing design.
- On start it latches the difficulty, drives max_digits to the digit-entry logic, and captures a secret number from a free-running decimal counter.
- Each confirmed guess is evaluated, and the block reports higher/lower hints, the remaining attempts, and win/lose status to the display logic.

---
 rtl/guess_game_pkg.sv | 31 +++
 rtl/guess_game_controller_seed.sv | 40 ++++
 rtl/guess_game_controller.sv | 168 ++++++++++++++++
 tb/tb_guess_game_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// Shared definitions for the number-guessing game controller.
//   game_state_t : sequencing FSM states
//   DIFF_*       : difficulty input codes
//   DEC_MAX      : largest legal decimal digit
//   bcd3_to_bin  : three BCD digits -> 10-bit binary value
package guess_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM        = 3'd1,
    S_WAIT_GUESS = 3'd2,
    S_LATCH      = 3'd3,
    S_EVAL       = 3'd4,
    S_WON        = 3'd5,
    S_LOST       = 3'd6
  } game_state_t;

  localparam logic [1:0] DIFF_EASY     = 2'd0;
  localparam logic [1:0] DIFF_MED      = 2'd1;
  localparam logic [1:0] DIFF_HARD     = 2'd2;
  localparam logic [1:0] DIFF_HARD_ALT = 2'd3;

  localparam logic [3:0] DEC_MAX = 4'd9;

  function automatic logic [9:0] bcd3_to_bin(input logic [3:0] d3,
                                             input logic [3:0] d2,
                                             input logic [3:0] d1);
    return ({6'd0, d3} * 10'd100) + ({6'd0, d2} * 10'd10) + {6'd0, d1};
  endfunction

endpackage

// File: rtl/guess_game_controller_seed.sv
// Free-running 3-digit BCD counter used as the secret-number source.
// Counts 000 -> 999 -> 000 every clock, independent of game state.
//   clk, reset : clock and asynchronous active-high reset (clears to 000)
//   o_d1..o_d3 : ones, tens, hundreds digits
module bcd_seed_counter
  import guess_game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] o_d1,
  output logic [3:0] o_d2,
  output logic [3:0] o_d3
);

  logic [3:0] r_d1, r_d2, r_d3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d1 <= 4'd0;
      r_d2 <= 4'd0;
      r_d3 <= 4'd0;
    end else if (r_d1 != DEC_MAX) begin
      r_d1 <= r_d1 + 4'd1;
    end else begin
      // ones wrap; carry ripples into tens, then hundreds
      r_d1 <= 4'd0;
      if (r_d2 != DEC_MAX) begin
        r_d2 <= r_d2 + 4'd1;
      end else begin
        r_d2 <= 4'd0;
        r_d3 <= (r_d3 == DEC_MAX) ? 4'd0 : r_d3 + 4'd1;
      end
    end
  end

  assign o_d1 = r_d1;
  assign o_d2 = r_d2;
  assign o_d3 = r_d3;

endmodule

// File: rtl/guess_game_controller.sv
// Game-sequencing FSM for the number-guessing design.
//   clk, reset          : clock, asynchronous active-high reset
//   start, difficulty   : begin a new game; difficulty sampled on accepted start
//   confirm             : guess locked; guess_digit_1..3 valid one cycle later
//   max_digits          : editable digit count while a guess is in play, else 0
//   attempts_left       : remaining guesses
//   hint_higher/lower   : last guess below / above the secret
//   win, lose           : held game result
//   busy                : high in ARM, WAIT_GUESS and EVAL
module guess_game_controller #(
  parameter logic [3:0] EASY_TRIES = 4'd5,
  parameter logic [3:0] MED_TRIES  = 4'd7,
  parameter logic [3:0] HARD_TRIES = 4'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] difficulty,
  input  logic       confirm,
  input  logic [3:0] guess_digit_1,
  input  logic [3:0] guess_digit_2,
  input  logic [3:0] guess_digit_3,
  output logic [1:0] max_digits,
  output logic [3:0] attempts_left,
  output logic       hint_higher,
  output logic       hint_lower,
  output logic       win,
  output logic       lose,
  output logic       busy
);
  import guess_game_pkg::*;

  game_state_t r_state;
  logic [1:0]  r_digits;
  logic [3:0]  r_attempts;
  logic [9:0]  r_secret;
  logic [3:0]  r_g1, r_g2, r_g3;
  logic        r_hint_h, r_hint_l, r_win, r_lose;

  logic [3:0]  w_seed_d1, w_seed_d2, w_seed_d3;
  logic [9:0]  w_seed_bin;
  logic [9:0]  w_guess_bin;

  function automatic logic [1:0] digits_for(input logic [1:0] diff);
    logic [1:0] n;
    case (diff)
      DIFF_EASY:               n = 2'd1;
      DIFF_MED:                n = 2'd2;
      DIFF_HARD, DIFF_HARD_ALT: n = 2'd3;
      default:                 n = 2'd3;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] tries_for(input logic [1:0] digits);
    logic [3:0] t;
    case (digits)
      2'd1:    t = EASY_TRIES;
      2'd2:    t = MED_TRIES;
      default: t = HARD_TRIES;
    endcase
    return t;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > DEC_MAX) ? DEC_MAX : d;
  endfunction

  bcd_seed_counter u_seed (
    .clk   (clk),
    .reset (reset),
    .o_d1  (w_seed_d1),
    .o_d2  (w_seed_d2),
    .o_d3  (w_seed_d3)
  );

  // Digits beyond the active digit count are forced to 0 on both the
  // secret and the guess, so the comparison only sees the playable range.
  always_comb begin
    w_seed_bin  = bcd3_to_bin((r_digits == 2'd3) ? w_seed_d3 : 4'd0,
                              (r_digits >= 2'd2) ? w_seed_d2 : 4'd0,
                              w_seed_d1);
    w_guess_bin = bcd3_to_bin((r_digits == 2'd3) ? clamp_digit(r_g3) : 4'd0,
                              (r_digits >= 2'd2) ? clamp_digit(r_g2) : 4'd0,
                              clamp_digit(r_g1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_digits   <= 2'd0;
      r_attempts <= 4'd0;
      r_secret   <= 10'd0;
      r_g1       <= 4'd0;
      r_g2       <= 4'd0;
      r_g3       <= 4'd0;
      r_hint_h   <= 1'b0;
      r_hint_l   <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_WON, S_LOST: begin
          if (start) begin
            r_digits <= digits_for(difficulty);
            r_state  <= S_ARM;
          end
        end
        S_ARM: begin
          r_attempts <= tries_for(r_digits);
          r_secret   <= w_seed_bin;
          r_hint_h   <= 1'b0;
          r_hint_l   <= 1'b0;
          r_win      <= 1'b0;
          r_lose     <= 1'b0;
          r_state    <= S_WAIT_GUESS;
        end
        S_WAIT_GUESS: begin
          // a restart request outranks a simultaneous confirm
          if (start) begin
            r_digits <= digits_for(difficulty);
            r_state  <= S_ARM;
          end else if (confirm) begin
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          // guess digits trail confirm by one register stage
          r_g1    <= guess_digit_1;
          r_g2    <= guess_digit_2;
          r_g3    <= guess_digit_3;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          if (w_guess_bin == r_secret) begin
            r_win    <= 1'b1;
            r_hint_h <= 1'b0;
            r_hint_l <= 1'b0;
            r_state  <= S_WON;
          end else begin
            r_hint_h <= (w_guess_bin < r_secret);
            r_hint_l <= (w_guess_bin > r_secret);
            if (r_attempts <= 4'd1) begin
              r_attempts <= 4'd0;
              r_lose     <= 1'b1;
              r_state    <= S_LOST;
            end else begin
              r_attempts <= r_attempts - 4'd1;
              r_state    <= S_WAIT_GUESS;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign max_digits    = (r_state == S_WAIT_GUESS || r_state == S_LATCH ||
                          r_state == S_EVAL) ? r_digits : 2'd0;
  assign busy          = (r_state == S_ARM || r_state == S_WAIT_GUESS ||
                          r_state == S_EVAL);
  assign attempts_left = r_attempts;
  assign hint_higher   = r_hint_h;
  assign hint_lower    = r_hint_l;
  assign win           = r_win;
  assign lose          = r_lose;

endmodule

// File: tb/tb_guess_game_controller.sv
// Self-checking bench for guess_game_controller with a game-level model.
module tb_guess_game_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] difficulty = 2'd0;
  logic       confirm = 1'b0;
  logic [3:0] guess_digit_1 = 4'd0;
  logic [3:0] guess_digit_2 = 4'd0;
  logic [3:0] guess_digit_3 = 4'd0;
  logic [1:0] max_digits;
  logic [3:0] attempts_left;
  logic       hint_higher, hint_lower, win, lose, busy;

  int checks = 0;
  int errors = 0;

  // game-level reference model
  int seed_m;
  int m_secret = 0, m_tries = 0, m_digits = 0;
  bit m_hh = 0, m_hl = 0, m_win = 0, m_lose = 0, m_active = 0;

  guess_game_controller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .difficulty    (difficulty),
    .confirm       (confirm),
    .guess_digit_1 (guess_digit_1),
    .guess_digit_2 (guess_digit_2),
    .guess_digit_3 (guess_digit_3),
    .max_digits    (max_digits),
    .attempts_left (attempts_left),
    .hint_higher   (hint_higher),
    .hint_lower    (hint_lower),
    .win           (win),
    .lose          (lose),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // seed value mirrors a decimal counter running since reset release
  always @(posedge clk or posedge reset) begin
    if (reset) seed_m <= 0;
    else       seed_m <= (seed_m + 1) % 1000;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".max_digits"}, 32'(max_digits), m_active ? 32'(m_digits) : 32'd0);
    chk({tag, ".attempts"},   32'(attempts_left), 32'(m_tries));
    chk({tag, ".hint_higher"}, 32'(hint_higher), 32'(m_hh));
    chk({tag, ".hint_lower"},  32'(hint_lower),  32'(m_hl));
    chk({tag, ".win"},         32'(win),         32'(m_win));
    chk({tag, ".lose"},        32'(lose),        32'(m_lose));
    chk({tag, ".busy"},        32'(busy),        32'(m_active));
  endtask

  function automatic int pow10(input int n);
    return (n == 1) ? 10 : (n == 2) ? 100 : 1000;
  endfunction

  function automatic int clampd(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_reset();
    m_tries = 0; m_hh = 0; m_hl = 0; m_win = 0; m_lose = 0; m_active = 0;
  endtask

  // Called at a negedge; issues start so that the ARM cycle sees seed == target.
  task automatic start_game(input string tag, input int target,
                            input logic [1:0] diff, input bit with_confirm);
    int want;
    int n;
    want = (target + 999) % 1000;
    n = 0;
    while (seed_m != want && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".seed_reached"}, 32'(seed_m), 32'(want));
    start = 1'b1;
    difficulty = diff;
    if (with_confirm) confirm = 1'b1;
    @(negedge clk);
    start = 1'b0;
    confirm = 1'b0;
    difficulty = 2'($urandom);
    chk({tag, ".arm_max_digits"}, 32'(max_digits), 32'd0);
    chk({tag, ".arm_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    m_digits = (diff == 2'd0) ? 1 : (diff == 2'd1) ? 2 : 3;
    m_secret = target % pow10(m_digits);
    m_tries  = (m_digits == 1) ? 5 : (m_digits == 2) ? 7 : 10;
    m_hh = 0; m_hl = 0; m_win = 0; m_lose = 0; m_active = 1;
    check_all(tag);
  endtask

  task automatic guess(input string tag, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] d3);
    int g;
    confirm = 1'b1;
    guess_digit_1 = 4'($urandom);
    guess_digit_2 = 4'($urandom);
    guess_digit_3 = 4'($urandom);
    @(negedge clk);
    confirm = 1'b0;
    guess_digit_1 = d1;
    guess_digit_2 = d2;
    guess_digit_3 = d3;
    chk({tag, ".latch_busy"}, 32'(busy), 32'd0);
    chk({tag, ".latch_max_digits"}, 32'(max_digits), 32'(m_digits));
    @(negedge clk);
    chk({tag, ".eval_busy"}, 32'(busy), 32'd1);
    chk({tag, ".eval_attempts"}, 32'(attempts_left), 32'(m_tries));
    g = clampd(d1) + ((m_digits >= 2) ? 10 * clampd(d2) : 0)
                   + ((m_digits == 3) ? 100 * clampd(d3) : 0);
    if (g == m_secret) begin
      m_win = 1; m_hh = 0; m_hl = 0; m_active = 0;
    end else begin
      m_hh = (g < m_secret);
      m_hl = (g > m_secret);
      if (m_tries == 1) begin
        m_tries = 0; m_lose = 1; m_active = 0;
      end else begin
        m_tries = m_tries - 1;
      end
    end
    @(negedge clk);
    check_all(tag);
    guess_digit_1 = 4'($urandom);
    guess_digit_2 = 4'($urandom);
    guess_digit_3 = 4'($urandom);
  endtask

  task automatic guess_val(input string tag, input int v);
    guess(tag, 4'(v % 10), 4'((v / 10) % 10), 4'(v / 100));
  endtask

  task automatic guess_wrong(input string tag);
    int lim;
    int v;
    lim = pow10(m_digits);
    v = (m_secret + 1 + int'($urandom_range(0, lim - 2))) % lim;
    guess_val(tag, v);
  endtask

  task automatic confirm_ignored(input string tag);
    confirm = 1'b1;
    @(negedge clk);
    confirm = 1'b0;
    repeat (3) @(negedge clk);
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(negedge clk);
    reset = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int n;
    logic [1:0] rd;

    // reset and idle behaviour
    repeat (2) @(negedge clk);
    check_all("reset_hold");
    reset = 1'b0;
    @(negedge clk);
    check_all("reset_release");
    confirm_ignored("idle_confirm");
    mid_reset("idle_reset");

    // easy game: secret from ones digit 7
    start_game("easy_start", 237, 2'd0, 1'b0);
    guess("easy_low", 4'd3, 4'd0, 4'd0);
    guess("easy_win", 4'd7, 4'd0, 4'd0);

    // hard game, bracketing around 512 (difficulty code 3)
    start_game("hard_start", 512, 2'd3, 1'b0);
    guess_val("hard_600", 600);
    guess_val("hard_400", 400);
    guess_val("hard_512", 512);

    // medium loss
    start_game("loss_start", int'($urandom_range(0, 999)), 2'd1, 1'b0);
    for (int i = 0; i < 7; i++) guess_wrong($sformatf("loss_g%0d", i));
    confirm_ignored("lost_confirm");

    // masking and clamping
    start_game("mask_start", 345, 2'd1, 1'b0);
    guess("mask_win", 4'd5, 4'd4, 4'd8);
    start_game("clamp_start", 745, 2'd1, 1'b0);
    guess("clamp_99", 4'd15, 4'd15, 4'd0);

    // restart during WAIT_GUESS
    start_game("rs_start", int'($urandom_range(0, 999)), 2'd0, 1'b0);
    guess_wrong("rs_w1");
    guess_wrong("rs_w2");
    chk("rs_attempts3", 32'(attempts_left), 32'd3);
    start_game("rs_restart", int'($urandom_range(0, 999)), 2'd2, 1'b0);
    guess_wrong("rs_w3");
    start_game("rs_start_confirm", int'($urandom_range(0, 999)), 2'd1, 1'b1);
    guess_wrong("rs_after");

    // random games
    for (int gnum = 0; gnum < 5; gnum++) begin
      rd = 2'($urandom);
      start_game($sformatf("rnd%0d_start", gnum), int'($urandom_range(0, 999)), rd, 1'b0);
      n = 0;
      while (m_active && n < 12) begin
        if ($urandom_range(0, 3) == 0)
          guess($sformatf("rnd%0d_g%0d", gnum, n), 4'(m_secret % 10),
                (m_digits >= 2) ? 4'((m_secret / 10) % 10) : 4'($urandom),
                (m_digits == 3) ? 4'(m_secret / 100) : 4'($urandom));
        else
          guess($sformatf("rnd%0d_g%0d", gnum, n), 4'($urandom), 4'($urandom), 4'($urandom));
        n++;
      end
    end

    // reset in the middle of a game
    start_game("mr_start", int'($urandom_range(0, 999)), 2'd2, 1'b0);
    guess_wrong("mr_w1");
    mid_reset("mid_game_reset");
    confirm_ignored("post_reset_confirm");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
